// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the clock period meter: FSM encoding and default parameters.
package clk_period_meter_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MEASURE = 1'b1
   } meter_state_e;

   localparam int unsigned DEFAULT_WIDTH   = 16;
   localparam int unsigned DEFAULT_TIMEOUT = 1000;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus one-cycle rise/fall strobes.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q;
   logic s2_q;
   logic prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= d_i;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign level_o = s2_q;
   assign rise_o  = s2_q & ~prev_q;
   assign fall_o  = ~s2_q & prev_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles,
// with lock (two equal periods) and sticky no-edge timeout.
module clk_period_meter
   import clk_period_meter_pkg::*;
#(
   parameter int unsigned WIDTH   = DEFAULT_WIDTH,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   output logic [WIDTH-1:0] period_o,
   output logic [WIDTH-1:0] high_o,
   output logic             valid_o,
   output logic             lock_o,
   output logic             timeout_o
);

   localparam logic [WIDTH-1:0] TimeoutW = WIDTH'(TIMEOUT);
   localparam logic [WIDTH-1:0] One      = WIDTH'(1);

   logic sig_level;
   logic sig_rise;
   logic sig_fall;

   sync_edge u_sync_edge (
      .clk     (clk),
      .rst     (rst),
      .d_i     (sig_in),
      .level_o (sig_level),
      .rise_o  (sig_rise),
      .fall_o  (sig_fall)
   );

   meter_state_e     state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hcnt_q, hcnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [WIDTH-1:0] high_q, high_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic             valid_q, valid_d;
   logic             lock_q, lock_d;
   logic             timeout_q, timeout_d;
   logic [WIDTH-1:0] cnt_inc;

   // cnt stays below TIMEOUT <= 2^WIDTH-1, so the increment never wraps.
   assign cnt_inc = cnt_q + One;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hcnt_d    = hcnt_q;
      period_d  = period_q;
      high_d    = high_q;
      last_d    = last_q;
      valid_d   = 1'b0;
      lock_d    = lock_q;
      timeout_d = timeout_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d  = '0;
            hcnt_d = '0;
            last_d = '0;
            if (sig_rise) begin
               state_d = ST_MEASURE;
               hcnt_d  = One;
            end
         end
         ST_MEASURE: begin
            // A rise in the same cycle as the timeout condition takes priority.
            if (sig_rise) begin
               period_d  = cnt_inc;
               high_d    = hcnt_q;
               valid_d   = 1'b1;
               cnt_d     = '0;
               hcnt_d    = One;
               timeout_d = 1'b0;
               lock_d    = (cnt_inc == last_q);
               last_d    = cnt_inc;
            end else if (cnt_inc == TimeoutW) begin
               timeout_d = 1'b1;
               lock_d    = 1'b0;
               state_d   = ST_IDLE;
               cnt_d     = '0;
               hcnt_d    = '0;
            end else begin
               cnt_d = cnt_inc;
               if (sig_level && (hcnt_q != '1)) begin
                  hcnt_d = hcnt_q + One;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hcnt_q    <= '0;
         period_q  <= '0;
         high_q    <= '0;
         last_q    <= '0;
         valid_q   <= 1'b0;
         lock_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hcnt_q    <= hcnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         last_q    <= last_d;
         valid_q   <= valid_d;
         lock_q    <= lock_d;
         timeout_q <= timeout_d;
      end
   end

   assign period_o  = period_q;
   assign high_o    = high_q;
   assign valid_o   = valid_q;
   assign lock_o    = lock_q;
   assign timeout_o = timeout_q;

   // A synchronized level cannot rise and fall in the same cycle.
   edge_exclusive_a: assert property (@(posedge clk) disable iff (rst) !(sig_rise && sig_fall));

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: one WIDTH=8/TIMEOUT=100 instance and one
// WIDTH=4/TIMEOUT=12 instance for the rise-versus-timeout boundary.
module tb_clk_period_meter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sig_a = 1'b0;
   logic       sig_b = 1'b0;

   logic [7:0] period_a, high_a;
   logic       valid_a, lock_a, timeout_a;
   logic [3:0] period_b, high_b;
   logic       valid_b, lock_b, timeout_b;

   int checks = 0;
   int failures = 0;

   always #10 clk = ~clk;

   clk_period_meter #(.WIDTH(8), .TIMEOUT(100)) u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .sig_in    (sig_a),
      .period_o  (period_a),
      .high_o    (high_a),
      .valid_o   (valid_a),
      .lock_o    (lock_a),
      .timeout_o (timeout_a)
   );

   clk_period_meter #(.WIDTH(4), .TIMEOUT(12)) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .sig_in    (sig_b),
      .period_o  (period_b),
      .high_o    (high_b),
      .valid_o   (valid_b),
      .lock_o    (lock_b),
      .timeout_o (timeout_b)
   );

   // Monitor samples on the falling edge, away from the active edge.
   int   cyc = 0;
   int   rec_per[$];
   int   rec_high[$];
   int   rec_lock[$];
   int   rec_to[$];
   int   last_valid_cyc = 0;
   int   to_cyc = 0;
   int   to_count_a = 0;
   int   nvalid_b = 0;
   logic timeout_a_d = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid_a) begin
         rec_per.push_back(int'(period_a));
         rec_high.push_back(int'(high_a));
         rec_lock.push_back(int'(lock_a));
         rec_to.push_back(int'(timeout_a));
         last_valid_cyc = cyc;
      end
      if (timeout_a && !timeout_a_d) begin
         to_count_a = to_count_a + 1;
         to_cyc     = cyc;
      end
      timeout_a_d = timeout_a;
      if (valid_b) nvalid_b = nvalid_b + 1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Each period: high for h cycles, then low for p-h cycles, changed on falling edges.
   task automatic drive(input int p, input int h, input int n, input bit on_b);
      for (int k = 0; k < n; k++) begin
         for (int c = 0; c < p; c++) begin
            @(negedge clk);
            if (on_b) sig_b = (c < h);
            else      sig_a = (c < h);
         end
      end
   endtask

   initial begin
      // Reset held 25 ns while the input toggles.
      for (int i = 0; i < 5; i++) begin
         #5 sig_a = ~sig_a;
      end
      chk("rst_period", int'(period_a), 0);
      chk("rst_high", int'(high_a), 0);
      chk("rst_lock", int'(lock_a), 0);
      chk("rst_timeout", int'(timeout_a), 0);
      chk("rst_valid", int'(valid_a), 0);
      sig_a = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_no_valid", rec_per.size(), 0);

      // Steady period 12, high 6: five rises give four measurements.
      drive(12, 6, 5, 1'b0);
      chk("p12_count", rec_per.size(), 4);
      chk("p12_first_period", rec_per[0], 12);
      chk("p12_first_high", rec_high[0], 6);
      chk("p12_first_lock", rec_lock[0], 0);
      chk("p12_second_lock", rec_lock[1], 1);
      chk("p12_last_period", rec_per[3], 12);
      chk("p12_last_lock", rec_lock[3], 1);
      chk("p12_hold_period", int'(period_a), 12);
      chk("p12_hold_high", int'(high_a), 6);

      // Switch to period 20, high 5.
      drive(20, 5, 3, 1'b0);
      chk("p20_count", rec_per.size(), 7);
      chk("p20_tail12_period", rec_per[4], 12);
      chk("p20_tail12_lock", rec_lock[4], 1);
      chk("p20_first_period", rec_per[5], 20);
      chk("p20_first_high", rec_high[5], 5);
      chk("p20_first_lock", rec_lock[5], 0);
      chk("p20_second_lock", rec_lock[6], 1);

      // Stop the input low: one timeout exactly 100 cycles after the last measurement.
      for (int i = 0; i < 200 && to_count_a == 0; i++) @(negedge clk);
      chk("stop_timeout_seen", to_count_a, 1);
      chk("stop_timeout_delay", to_cyc - last_valid_cyc, 100);
      chk("stop_timeout_flag", int'(timeout_a), 1);
      chk("stop_lock", int'(lock_a), 0);
      repeat (150) @(negedge clk);
      chk("stop_timeout_sticky", int'(timeout_a), 1);
      chk("stop_single_timeout", to_count_a, 1);
      chk("stop_no_valid", rec_per.size(), 7);

      // Restart: the first rise only re-arms, the second measures and clears timeout.
      drive(12, 6, 1, 1'b0);
      chk("restart_first_no_valid", rec_per.size(), 7);
      chk("restart_timeout_held", int'(timeout_a), 1);
      drive(12, 6, 2, 1'b0);
      chk("restart_count", rec_per.size(), 9);
      chk("restart_period", rec_per[7], 12);
      chk("restart_timeout_clear", rec_to[7], 0);
      chk("restart_first_lock", rec_lock[7], 0);
      chk("restart_second_lock", rec_lock[8], 1);

      // Asynchronous reset between clock edges while measuring.
      @(negedge clk);
      sig_a = 1'b1;
      @(negedge clk);
      chk("arst_pre_lock", int'(lock_a), 1);
      #3 rst = 1'b1;
      #1;
      chk("arst_period", int'(period_a), 0);
      chk("arst_high", int'(high_a), 0);
      chk("arst_lock", int'(lock_a), 0);
      chk("arst_timeout", int'(timeout_a), 0);
      chk("arst_valid", int'(valid_a), 0);
      @(negedge clk);
      sig_a = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      drive(12, 6, 3, 1'b0);
      chk("arst_after_count", rec_per.size(), 11);
      chk("arst_after_period", rec_per[9], 12);
      chk("arst_after_first_lock", rec_lock[9], 0);
      chk("arst_after_second_lock", rec_lock[10], 1);

      // TIMEOUT=12: period 12 never times out, period 13 does.
      drive(12, 6, 5, 1'b1);
      chk("b12_count", nvalid_b, 4);
      chk("b12_period", int'(period_b), 12);
      chk("b12_high", int'(high_b), 6);
      chk("b12_lock", int'(lock_b), 1);
      chk("b12_no_timeout", int'(timeout_b), 0);
      drive(13, 6, 2, 1'b1);
      chk("b13_timeout", int'(timeout_b), 1);
      chk("b13_lock", int'(lock_b), 0);
      chk("b13_count", nvalid_b, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
